// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory bus bundle for the two-port memory arbiter
// Parameters: WIDTH data width, AW address width.
// slave modport (arbiter side):
//   in  cpu_req/cpu_wen/cpu_addr/cpu_wdata, dbg_req/dbg_wen/dbg_addr/dbg_wdata, mem_rdata/mem_ready
//   out cpu_ack/cpu_rdata, dbg_ack/dbg_rdata, mem_cs/mem_wen/mem_addr/mem_wdata, owner
// master modport (requesters plus memory): the mirror image.
interface mem_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW = 16
);
  logic cpu_req;
  logic cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic cpu_ack;
  logic [WIDTH-1:0] cpu_rdata;
  logic dbg_req;
  logic dbg_wen;
  logic [AW-1:0] dbg_addr;
  logic [WIDTH-1:0] dbg_wdata;
  logic dbg_ack;
  logic [WIDTH-1:0] dbg_rdata;
  logic mem_cs;
  logic mem_wen;
  logic [AW-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic mem_ready;
  logic [1:0] owner;
  modport slave (
    input cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input dbg_req, dbg_wen, dbg_addr, dbg_wdata,
    input mem_rdata, mem_ready,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    output mem_cs, mem_wen, mem_addr, mem_wdata, owner
  );
  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output dbg_req, dbg_wen, dbg_addr, dbg_wdata,
    output mem_rdata, mem_ready,
    input cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    input mem_cs, mem_wen, mem_addr, mem_wdata, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU and debug buses, one transaction at a time
// Ports: clk system clock; reset synchronous active-low; bus mem_arbiter_if.slave carrying
//   both requester ports (req/wen/addr/wdata in, ack/rdata out), the memory port
//   (cs/wen/addr/wdata out, rdata/ready in) and the owner status (00 idle, 01 CPU, 10 debug).
// Option: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the CPU wins every tie.
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW = 16
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state;
  logic pick_dbg;
  logic sel_wen;
  logic [AW-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
`ifdef MEM_ARB_RR_EN
  // set when the debug port took the most recent grant; reset value makes the CPU win the first tie
  logic last_dbg;
  always_comb pick_dbg = bus.dbg_req & (~bus.cpu_req | ~last_dbg);
`else
  always_comb pick_dbg = bus.dbg_req & ~bus.cpu_req;
`endif
  always_comb begin
    sel_wen = pick_dbg ? bus.dbg_wen : bus.cpu_wen;
    sel_addr = pick_dbg ? bus.dbg_addr : bus.cpu_addr;
    sel_wdata = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      bus.mem_cs <= 1'b0;
      bus.mem_wen <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
      bus.owner <= 2'b00;
`ifdef MEM_ARB_RR_EN
      last_dbg <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (bus.cpu_req | bus.dbg_req) begin
          bus.mem_cs <= 1'b1;
          bus.mem_wen <= sel_wen;
          bus.mem_addr <= sel_addr;
          bus.mem_wdata <= sel_wdata;
          bus.owner <= pick_dbg ? 2'b10 : 2'b01;
`ifdef MEM_ARB_RR_EN
          last_dbg <= pick_dbg;
`endif
          state <= ACCESS;
        end
        ACCESS: if (bus.mem_ready) begin
          // owner still names the winner here, so it steers the read data and the ack
          if (!bus.mem_wen && bus.owner[0]) bus.cpu_rdata <= bus.mem_rdata;
          if (!bus.mem_wen && bus.owner[1]) bus.dbg_rdata <= bus.mem_rdata;
          bus.mem_cs <= 1'b0;
          bus.cpu_ack <= bus.owner[0];
          bus.dbg_ack <= bus.owner[1];
          state <= ACK;
        end
        ACK: begin
          bus.cpu_ack <= 1'b0;
          bus.dbg_ack <= 1'b0;
          bus.owner <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter for the processor computer. Shares the single-port program/data memory between the CPU bus and a debug/monitor bus (program loader, test_sel inspection), one transaction at a time. Sits between the CPU core and the memory inside `computer`, and runs on the system clock.

## Interface
Parameters:
- `WIDTH`, 32: data width of both requester buses and the memory.
- `AW`, 16: address width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset==0` at a rising edge resets the block.
- `cpu_req`  in  1  CPU transaction request; held until `cpu_ack`.
- `cpu_wen`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  WIDTH  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  WIDTH  CPU read data, valid with `cpu_ack`, held afterwards.
- `dbg_req`, `dbg_wen`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: debug port, same widths and rules as the CPU port.
- `mem_cs`  out  1  memory access strobe.
- `mem_wen`  out  1  memory write enable, qualified by `mem_cs`.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  WIDTH  memory write data.
- `mem_rdata`  in  WIDTH  memory read data, valid when `mem_ready`=1.
- `mem_ready`  in  1  memory completion; may take any number of cycles.
- `owner`  out  2  status: 00 idle, 01 CPU, 10 debug; routable to `test_out`.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE: if neither request is active, stay. Otherwise pick a winner by policy (see Configuration), register its `wen/addr/wdata` onto `mem_*`, set `mem_cs`=1 and `owner`, then go to ACCESS.
- ACCESS: `mem_*` held stable. When `mem_ready`=1 is sampled: on a read, capture `mem_rdata` into the winner's `rdata`; on a write, leave `rdata` unchanged. Drop `mem_cs`, assert the winner's `ack`, go to ACK.
- ACK: winner's `ack`=1 for exactly this cycle. No grant is made in this state. Go to IDLE next.
- Requesters must hold `req` and their signals until they see `ack`. A requester may keep `req` high through ACK to issue a back-to-back transaction; it is then arbitrated again in IDLE.
- Request signals are only sampled in IDLE. Changes during ACCESS/ACK do not affect the transaction in flight.
- `mem_ready` outside ACCESS is ignored.
- The loser's request stays pending; it has no other side effect.
- `owner` returns to 00 in IDLE.

## Timing
- Reset values: `mem_cs`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_ack`=`dbg_ack`=0, `cpu_rdata`=`dbg_rdata`=0, `owner`=00, state IDLE, RR pointer = "debug served last".
- Request seen at edge N: `mem_cs` high after edge N. If `mem_ready`=1 at edge N+k (k≥1), `ack` is high between edges N+k and N+k+1, with `rdata` valid in that window.
- Minimum transaction length is 3 cycles (zero-wait memory returns `mem_ready` in the first ACCESS cycle). Maximum back-to-back throughput is one transaction per 3 cycles.
- Reset asserted mid-transaction: the transaction is abandoned and all outputs take their reset values at that edge. No `ack` is issued for the abandoned transaction.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a simultaneous request, the port not served last wins. The pointer updates at every grant. After reset the CPU wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority; the CPU always wins a tie. The debug port is granted only when `cpu_req`=0 in IDLE. The RR pointer logic is not present.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with both requests high -> all outputs zero, no `mem_cs`. Release -> CPU granted first, `owner`=01.
- CPU read, zero-wait: `cpu_addr`=0x0010 and `mem_rdata`=0xDEADBEEF -> `mem_cs` for 1 cycle, then `cpu_ack` with `cpu_rdata`=0xDEADBEEF. Total 3 cycles; `dbg_ack` stays 0.
- Debug write with `mem_ready` delayed 4 cycles: `dbg_wdata`=0x12345678 -> `mem_cs`/`mem_wen`/`mem_addr` stable for all 4 cycles, then `dbg_ack`. `dbg_rdata` unchanged.
- Both requesting continuously for 6 transactions: with RR the grants are CPU, DBG, CPU, DBG, CPU, DBG. Without RR they are all CPU, and `dbg_ack` never pulses.
- Reset in the 2nd ACCESS cycle of a CPU read -> no `cpu_ack`, `cpu_rdata`=0, `mem_cs`=0 at that edge. After release, a pending debug request is served normally.
- `mem_ready` pulsed while in IDLE and in ACK -> ignored: no ack, no `rdata` change.
